pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the IF stage of the pipelined CPU. It holds the architectural fetch PC in a register and advances it by a configurable step each cycle. It handles stall holds, branch/jump redirects from later stages, and a sticky halt state with explicit resume. It also exposes the combinational next-PC, an alignment fault flag and a fetch counter.

## Interface

- WIDTH, 32, PC width in bits
- STEP, 4, increment added per advancing cycle (modulo 2^WIDTH)
- RESET_PC, 32'h0000_0000, PC value loaded on reset (truncated to WIDTH)
- ALIGN_BITS, 2, number of low PC bits that must be zero; 0 disables the alignment check
- CNT_W, 32, width of the fetch counter

Ports:

- clk  in  1  system clock, all state updates on rising edge
- rstn  in  1  reset, asynchronous assert, active-low
- stall_i  in  1  hazard stall: hold PC this cycle
- redirect_i  in  1  load redirect_pc_i (branch/jump taken)
- redirect_pc_i  in  WIDTH  redirect target
- halt_i  in  1  request halt (halt instruction decoded)
- resume_i  in  1  leave HALTED state
- pc_o  out  WIDTH  current fetch PC (registered)
- pc_next_o  out  WIDTH  value pc_o will take at next edge (combinational)
- pc_valid_o  out  1  1 when pc_o is a live fetch (state RUN)
- halted_o  out  1  1 in state HALTED (registered)
- misalign_o  out  1  registered one-cycle pulse: last loaded redirect target was misaligned
- fetch_cnt_o  out  CNT_W  number of cycles in which the PC advanced or was redirected

## Operation

- States: RUN, HALTED. Two-state FSM with a registered state bit.
- RUN, evaluated in this priority order:
  - redirect_i=1: load redirect_pc_i. Redirect overrides stall_i and halt_i in the same cycle.
  - stall_i=1: hold the PC.
  - halt_i=1: hold the PC and go to HALTED.
  - otherwise: pc <= pc + STEP.
- HALTED:
  - PC held; stall_i and halt_i ignored.
  - resume_i=0: redirect_i ignored.
  - resume_i=1 and redirect_i=1: load redirect_pc_i and go to RUN.
  - resume_i=1 and redirect_i=0: go to RUN with the PC held. The first RUN cycle fetches the held PC.
- Arithmetic: sum truncated to WIDTH, so 2^WIDTH−STEP wraps to 0. No overflow flag.
- Alignment: a loaded target with nonzero redirect_pc_i[ALIGN_BITS-1:0] is loaded unmodified and sets misalign_o for exactly one cycle. Sequential increments never assert misalign_o.
- fetch_cnt_o increments on every advance or accepted redirect and wraps at 2^CNT_W. Hold cycles (stall, halt entry, HALTED, resume without redirect) do not count.
- pc_next_o reflects the same priority logic as the register update.
- pc_valid_o = (state==RUN). halted_o = (state==HALTED).

## Timing

- Reset (rstn=0, asynchronous): pc_o=RESET_PC, state RUN, pc_valid_o=1, halted_o=0, misalign_o=0, fetch_cnt_o=0.
- Reset asserted mid-operation overrides everything immediately, without waiting for a clock edge.
- First edge after rstn rises with no stall/halt/redirect: pc_o=RESET_PC+STEP.
- Latency:
  - Redirect, halt and resume take effect at the next rising edge; pc_o shows the new value one cycle after the request.
  - halted_o rises on the edge that samples halt_i.
  - misalign_o is high in the cycle after the misaligned load edge.
- pc_next_o has zero latency and is valid within the same cycle as its inputs.
- All inputs are sampled at the rising edge only. Level-held halt_i or resume_i produce no repeated side effects.

## Test plan

- Reset, then 3 free cycles, STEP=4, RESET_PC=0x3000 -> pc_o 0x3000, 0x3004, 0x3008, 0x300C; fetch_cnt_o=3.
- pc_o=0x3010: assert stall_i and redirect_i (target 0x4000) together, then stall_i alone for 2 cycles -> pc_o 0x4000, 0x4000, 0x4000; then 0x4004 after release.
- pc_o=0x3020, halt_i=1 one cycle -> halted_o=1, pc_valid_o=0, pc_o stays 0x3020. A redirect to 0x5000 without resume is ignored. resume_i=1 -> RUN, pc_o 0x3020, then 0x3024.
- HALTED with resume_i=1 and redirect to 0x5002 -> pc_o=0x5002, misalign_o=1 for exactly one cycle, state RUN.
- WIDTH=32 with pc_o=0xFFFF_FFFC, advance -> pc_o=0x0000_0000, no misalign. CNT_W=4 with fetch_cnt_o=15, advance -> 0.
- Mid-run with pc_o=0x3100 in HALTED, drop rstn asynchronously between edges -> outputs return to reset values immediately, before the next edge.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential advance, stall hold, redirect,
// sticky halt with explicit resume, misaligned-target flag and fetch counter.
module pc_gen #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned STEP       = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned ALIGN_BITS = 2,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    input  logic             halt_i,
    input  logic             resume_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_next_o,
    output logic             pc_valid_o,
    output logic             halted_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    localparam logic [WIDTH-1:0] RESET_VAL  = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] STEP_VAL   = WIDTH'(STEP);
    // Mask of low bits that must be zero; all-zero mask disables the check.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             misalign_q, misalign_d;
    logic             load_c;
    logic             adv_c;

    // Next-state, next-PC and side-flag decode
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        load_c     = 1'b0;
        adv_c      = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (redirect_i) begin
                    load_c = 1'b1;
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else if (halt_i) begin
                    state_d = ST_HALTED;
                end else begin
                    adv_c = 1'b1;
                end
            end
            ST_HALTED: begin
                if (resume_i) begin
                    state_d = ST_RUN;
                    load_c  = redirect_i;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (load_c) begin
            pc_d = redirect_pc_i;
        end else if (adv_c) begin
            pc_d = pc_q + STEP_VAL;
        end

        cnt_d      = (load_c || adv_c) ? cnt_q + CNT_W'(1) : cnt_q;
        misalign_d = load_c && ((redirect_pc_i & ALIGN_MASK) != '0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_VAL;
            cnt_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o        = pc_q;
    assign pc_next_o   = pc_d;
    assign pc_valid_o  = (state_q == ST_RUN);
    assign halted_o    = (state_q == ST_HALTED);
    assign misalign_o  = misalign_q;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vectors with literal expectations
// plus a per-cycle comparison against a behavioural fetch-PC model.
module tb_pc_gen;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             stall_i, redirect_i, halt_i, resume_i;
    logic [WIDTH-1:0] redirect_pc_i;
    logic [WIDTH-1:0] pc_o, pc_next_o;
    logic             pc_valid_o, halted_o, misalign_o;
    logic [CNT_W-1:0] fetch_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    pc_gen #(
        .WIDTH(WIDTH), .STEP(4), .RESET_PC(32'h0000_3000),
        .ALIGN_BITS(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rstn(rstn), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .halt_i(halt_i), .resume_i(resume_i),
        .pc_o(pc_o), .pc_next_o(pc_next_o), .pc_valid_o(pc_valid_o),
        .halted_o(halted_o), .misalign_o(misalign_o), .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_pc     = 32'h3000;
    bit          m_halted = 1'b0;
    int          m_cnt    = 0;
    bit          m_mis    = 1'b0;

    function automatic void predict(output logic [31:0] npc, output bit nh, output bit taken,
                                    output bit counted);
        npc = m_pc; nh = m_halted; taken = 1'b0; counted = 1'b0;
        if (!m_halted) begin
            if (redirect_i)   begin npc = redirect_pc_i; taken = 1'b1; end
            else if (stall_i) begin end
            else if (halt_i)  nh = 1'b1;
            else              begin npc = m_pc + 32'd4; counted = 1'b1; end
        end else if (resume_i) begin
            nh = 1'b0;
            if (redirect_i) begin npc = redirect_pc_i; taken = 1'b1; end
        end
        if (taken) counted = 1'b1;
    endfunction

    always @(posedge clk or negedge rstn) begin : model
        logic [31:0] npc;
        bit nh, taken, counted;
        if (!rstn) begin
            m_pc = 32'h3000; m_halted = 1'b0; m_cnt = 0; m_mis = 1'b0;
        end else begin
            predict(npc, nh, taken, counted);
            m_mis    = taken && (npc[1:0] != 2'b00);
            m_pc     = npc;
            m_halted = nh;
            if (counted) m_cnt = (m_cnt + 1) % 16;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin : compare
        logic [31:0] npc;
        bit nh, taken, counted;
        if (chk_en) begin
            predict(npc, nh, taken, counted);
            chk("m_pc",       64'(pc_o),        64'(m_pc));
            chk("m_pc_next",  64'(pc_next_o),   64'(npc));
            chk("m_valid",    64'(pc_valid_o),  64'(!m_halted));
            chk("m_halted",   64'(halted_o),    64'(m_halted));
            chk("m_misalign", 64'(misalign_o),  64'(m_mis));
            chk("m_cnt",      64'(fetch_cnt_o), 64'(m_cnt));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input bit s, input bit r, input logic [31:0] t, input bit h, input bit res);
        stall_i = s; redirect_i = r; redirect_pc_i = t; halt_i = h; resume_i = res;
    endtask

    task automatic hc(input string nm, input logic [31:0] pc, input int cnt, input bit h,
                      input bit mis);
        chk({nm, "_pc"},    64'(pc_o),        64'(pc));
        chk({nm, "_cnt"},   64'(fetch_cnt_o), 64'(cnt));
        chk({nm, "_halt"},  64'(halted_o),    64'(h));
        chk({nm, "_valid"}, 64'(pc_valid_o),  64'(!h));
        chk({nm, "_mis"},   64'(misalign_o),  64'(mis));
    endtask

    initial begin
        rstn = 1'b0;
        apply(0, 0, 32'h0, 0, 0);
        repeat (2) cyc();
        hc("reset", 32'h3000, 0, 0, 0);
        chk_en = 1'b1;
        rstn   = 1'b1;
        cyc(); hc("free1", 32'h3004, 1, 0, 0);
        cyc(); hc("free2", 32'h3008, 2, 0, 0);
        cyc(); hc("free3", 32'h300C, 3, 0, 0);
        cyc(); hc("free4", 32'h3010, 4, 0, 0);

        // Redirect beats stall in the same cycle
        apply(1, 1, 32'h4000, 0, 0);
        #1 chk("next_redir", 64'(pc_next_o), 64'h4000);
        cyc(); hc("st_redir", 32'h4000, 5, 0, 0);
        apply(1, 0, 32'h0, 0, 0);
        cyc(); hc("stall1", 32'h4000, 5, 0, 0);
        cyc(); hc("stall2", 32'h4000, 5, 0, 0);
        apply(0, 0, 32'h0, 0, 0);
        cyc(); hc("release", 32'h4004, 6, 0, 0);

        // Halt, ignored redirect, plain resume
        apply(0, 1, 32'h3020, 0, 0);
        cyc(); hc("to3020", 32'h3020, 7, 0, 0);
        apply(0, 0, 32'h0, 1, 0);
        cyc(); hc("halt", 32'h3020, 7, 1, 0);
        apply(0, 1, 32'h5000, 0, 0);
        cyc(); hc("halt_redir", 32'h3020, 7, 1, 0);
        apply(0, 0, 32'h0, 0, 1);
        cyc(); hc("resume", 32'h3020, 7, 0, 0);
        apply(0, 0, 32'h0, 0, 0);
        cyc(); hc("post_res", 32'h3024, 8, 0, 0);

        // Resume with misaligned redirect
        apply(0, 0, 32'h0, 1, 0);
        cyc(); hc("halt2", 32'h3024, 8, 1, 0);
        apply(0, 1, 32'h5002, 0, 1);
        cyc(); hc("res_mis", 32'h5002, 9, 0, 1);
        apply(0, 0, 32'h0, 0, 0);
        cyc(); hc("mis_drop", 32'h5006, 10, 0, 0);

        // PC wrap, then counter wrap
        apply(0, 1, 32'hFFFF_FFFC, 0, 0);
        cyc(); hc("to_top", 32'hFFFF_FFFC, 11, 0, 0);
        apply(0, 0, 32'h0, 0, 0);
        cyc(); hc("pc_wrap", 32'h0000_0000, 12, 0, 0);
        cyc(); cyc(); cyc(); hc("cnt15", 32'h0000_000C, 15, 0, 0);
        cyc(); hc("cnt_wrap", 32'h0000_0010, 0, 0, 0);

        // Asynchronous reset while halted
        apply(0, 1, 32'h3100, 0, 0);
        cyc(); hc("to3100", 32'h3100, 1, 0, 0);
        apply(0, 0, 32'h0, 1, 0);
        cyc(); hc("halt3", 32'h3100, 1, 1, 0);
        apply(0, 0, 32'h0, 0, 0);
        #2 rstn = 1'b0;
        #1 hc("async_rst", 32'h3000, 0, 0, 0);
        cyc(); cyc();
        rstn = 1'b1;
        cyc(); hc("after_rst", 32'h3004, 1, 0, 0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
